// File: rtl/sync_pkt_fifo.sv
// Packet-mode synchronous FIFO: frames become readable only once committed by
// a clean LAST. Errored or overflowing frames are rewound to their start slot.
module sync_pkt_fifo #(
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned WIDTH      = 64,
  parameter int unsigned PKT_DEPTH  = 16,
  parameter int unsigned FWFT       = 1,
  parameter int unsigned AF_THRESH  = 8,
  parameter int unsigned BADDR      = $clog2(DEPTH),
  parameter int unsigned CNT_WIDTH  = $clog2(DEPTH + 1),
  parameter int unsigned PCNT_WIDTH = $clog2(PKT_DEPTH + 1)
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  WR_EN,
  input  logic [WIDTH-1:0]      DIN,
  input  logic                  WR_LAST,
  input  logic                  WR_ERR,
  output logic                  FULL,
  output logic                  ALMOST_FULL,
  output logic                  WR_DROP,
  input  logic                  RD_EN,
  output logic [WIDTH-1:0]      DOUT,
  output logic                  RD_LAST,
  output logic                  EMPTY,
  output logic [CNT_WIDTH-1:0]  DATA_CNT,
  output logic [PCNT_WIDTH-1:0] PKT_CNT
);

  localparam logic [BADDR-1:0] LAST_IDX = BADDR'(DEPTH - 1);

  logic [WIDTH:0]          r_mem [DEPTH];
  logic [BADDR-1:0]        r_wr_ptr, r_cmt_ptr, r_rd_ptr;
  logic [CNT_WIDTH-1:0]    r_data_cnt;
  logic [CNT_WIDTH-1:0]    r_ucnt;      // words of the frame currently being written
  logic [PCNT_WIDTH-1:0]   r_pkt_cnt;
  logic                    r_ovf;
  logic                    r_wr_drop;
  logic [WIDTH-1:0]        r_dout;
  logic                    r_rd_last;

  logic [CNT_WIDTH:0]      w_used, w_free;
  logic                    w_full, w_empty;
  logic                    w_wr_acc, w_end, w_drop, w_commit;
  logic                    w_pop, w_pop_last;
  logic [WIDTH:0]          w_head;
  logic [BADDR-1:0]        w_wr_nxt, w_rd_nxt;
  logic [CNT_WIDTH-1:0]    w_add, w_sub;

  function automatic logic [BADDR-1:0] f_inc(input logic [BADDR-1:0] p);
    return (p == LAST_IDX) ? '0 : p + BADDR'(1);
  endfunction

  assign w_used     = {1'b0, r_data_cnt} + {1'b0, r_ucnt};
  assign w_free     = (CNT_WIDTH+1)'(DEPTH) - w_used;
  assign w_full     = (w_used == (CNT_WIDTH+1)'(DEPTH)) | (r_pkt_cnt == PCNT_WIDTH'(PKT_DEPTH));
  assign w_empty    = (r_data_cnt == '0);
  assign w_wr_acc   = WR_EN & ~w_full & ~r_ovf;
  assign w_end      = WR_EN & WR_LAST;
  assign w_drop     = w_end & (WR_ERR | r_ovf | w_full);
  assign w_commit   = w_end & ~w_drop;
  assign w_head     = r_mem[r_rd_ptr];
  assign w_pop      = RD_EN & ~w_empty;
  assign w_pop_last = w_pop & w_head[WIDTH];
  assign w_wr_nxt   = f_inc(r_wr_ptr);
  assign w_rd_nxt   = f_inc(r_rd_ptr);
  assign w_add      = w_commit ? (r_ucnt + CNT_WIDTH'(1)) : '0;
  assign w_sub      = CNT_WIDTH'(w_pop);

  // Storage: only accepted words are written, always into uncommitted space
  always_ff @(posedge CLK) begin
    if (w_wr_acc) r_mem[r_wr_ptr] <= {WR_LAST, DIN};
  end

  // Write side: speculative pointer, commit pointer, overflow flag, drop pulse
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_wr_ptr  <= '0;
      r_cmt_ptr <= '0;
      r_ucnt    <= '0;
      r_ovf     <= 1'b0;
      r_wr_drop <= 1'b0;
    end else begin
      r_wr_drop <= w_drop;
      if (w_drop) begin
        r_wr_ptr <= r_cmt_ptr;
        r_ucnt   <= '0;
        r_ovf    <= 1'b0;
      end else if (w_commit) begin
        r_wr_ptr  <= w_wr_nxt;
        r_cmt_ptr <= w_wr_nxt;
        r_ucnt    <= '0;
      end else if (w_wr_acc) begin
        r_wr_ptr <= w_wr_nxt;
        r_ucnt   <= r_ucnt + CNT_WIDTH'(1);
      end else if (WR_EN & w_full) begin
        r_ovf <= 1'b1;
      end
    end
  end

  // Read side and shared counts; commit and pop deltas combine in one update
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_rd_ptr   <= '0;
      r_data_cnt <= '0;
      r_pkt_cnt  <= '0;
      r_dout     <= '0;
      r_rd_last  <= 1'b0;
    end else begin
      r_data_cnt <= r_data_cnt + w_add - w_sub;
      r_pkt_cnt  <= r_pkt_cnt + PCNT_WIDTH'(w_commit) - PCNT_WIDTH'(w_pop_last);
      if (w_pop) begin
        r_rd_ptr  <= w_rd_nxt;
        r_dout    <= w_head[WIDTH-1:0];
        r_rd_last <= w_head[WIDTH];
      end
    end
  end

  assign FULL        = w_full;
  assign ALMOST_FULL = (32'(w_free) <= AF_THRESH);
  assign WR_DROP     = r_wr_drop;
  assign EMPTY       = w_empty;
  assign DATA_CNT    = r_data_cnt;
  assign PKT_CNT     = r_pkt_cnt;
  assign DOUT        = (FWFT != 0) ? (w_empty ? '0 : w_head[WIDTH-1:0]) : r_dout;
  assign RD_LAST     = (FWFT != 0) ? (~w_empty & w_head[WIDTH]) : r_rd_last;

endmodule

// File: tb/tb_sync_pkt_fifo.sv
// Directed bench for sync_pkt_fifo: three instances cover the 8-deep FWFT case,
// the frame-count limit, and the 5-deep registered-read wrap case.
module tb_sync_pkt_fifo;

  logic clk = 1'b0;
  logic rst_n;
  logic [2:0]       wr_en, wr_last, wr_err, rd_en;
  logic [2:0][15:0] din, dout;
  logic [2:0]       full, af, drop, rd_last, empty;
  logic [2:0][3:0]  dc;
  logic [2:0][4:0]  pc;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sync_pkt_fifo #(.DEPTH(8), .WIDTH(16), .PKT_DEPTH(16), .FWFT(1), .AF_THRESH(2),
                  .CNT_WIDTH(4), .PCNT_WIDTH(5)) u_a (
    .CLK(clk), .RST_N(rst_n), .WR_EN(wr_en[0]), .DIN(din[0]), .WR_LAST(wr_last[0]),
    .WR_ERR(wr_err[0]), .FULL(full[0]), .ALMOST_FULL(af[0]), .WR_DROP(drop[0]),
    .RD_EN(rd_en[0]), .DOUT(dout[0]), .RD_LAST(rd_last[0]), .EMPTY(empty[0]),
    .DATA_CNT(dc[0]), .PKT_CNT(pc[0]));

  sync_pkt_fifo #(.DEPTH(8), .WIDTH(16), .PKT_DEPTH(2), .FWFT(1), .AF_THRESH(2),
                  .CNT_WIDTH(4), .PCNT_WIDTH(5)) u_b (
    .CLK(clk), .RST_N(rst_n), .WR_EN(wr_en[1]), .DIN(din[1]), .WR_LAST(wr_last[1]),
    .WR_ERR(wr_err[1]), .FULL(full[1]), .ALMOST_FULL(af[1]), .WR_DROP(drop[1]),
    .RD_EN(rd_en[1]), .DOUT(dout[1]), .RD_LAST(rd_last[1]), .EMPTY(empty[1]),
    .DATA_CNT(dc[1]), .PKT_CNT(pc[1]));

  sync_pkt_fifo #(.DEPTH(5), .WIDTH(16), .PKT_DEPTH(4), .FWFT(0), .AF_THRESH(1),
                  .CNT_WIDTH(4), .PCNT_WIDTH(5)) u_c (
    .CLK(clk), .RST_N(rst_n), .WR_EN(wr_en[2]), .DIN(din[2]), .WR_LAST(wr_last[2]),
    .WR_ERR(wr_err[2]), .FULL(full[2]), .ALMOST_FULL(af[2]), .WR_DROP(drop[2]),
    .RD_EN(rd_en[2]), .DOUT(dout[2]), .RD_LAST(rd_last[2]), .EMPTY(empty[2]),
    .DATA_CNT(dc[2]), .PKT_CNT(pc[2]));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int k, input logic [15:0] d, input bit last, input bit err);
    wr_en[k] = 1'b1; din[k] = d; wr_last[k] = last; wr_err[k] = err;
    tick();
    wr_en[k] = 1'b0; wr_last[k] = 1'b0; wr_err[k] = 1'b0;
  endtask

  task automatic pop(input int k);
    rd_en[k] = 1'b1;
    tick();
    rd_en[k] = 1'b0;
  endtask

  // FWFT read: head word must already be visible, then pop it
  task automatic rd_chk(input int k, input logic [15:0] d, input bit last, input string tag);
    check_eq({tag, "_dout"}, dout[k], d);
    check_eq({tag, "_last"}, rd_last[k], last);
    pop(k);
  endtask

  initial begin
    rst_n = 1'b0;
    wr_en = '0; wr_last = '0; wr_err = '0; rd_en = '0; din = '0;
    #2;
    check_eq("rst_empty", empty[0], 1);
    check_eq("rst_full", full[0], 0);
    check_eq("rst_dc", dc[0], 0);
    check_eq("rst_pc", pc[0], 0);
    check_eq("rst_dout", dout[0], 0);
    check_eq("rst_drop", drop[0], 0);
    check_eq("rst_dout_reg", dout[2], 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();

    // Good 3-word frame
    push(0, 16'hA000, 0, 0);
    check_eq("A_empty_mid", empty[0], 1);
    push(0, 16'hA001, 0, 0);
    push(0, 16'hA002, 1, 0);
    check_eq("A_empty", empty[0], 0);
    check_eq("A_dc", dc[0], 3);
    check_eq("A_pc", pc[0], 1);
    rd_chk(0, 16'hA000, 0, "A0");
    rd_chk(0, 16'hA001, 0, "A1");
    rd_chk(0, 16'hA002, 1, "A2");
    check_eq("A_pc_end", pc[0], 0);
    check_eq("A_empty_end", empty[0], 1);

    // Errored frame is dropped, next frame reuses the slot
    push(0, 16'hB000, 0, 0);
    push(0, 16'hB001, 0, 0);
    push(0, 16'hB002, 0, 0);
    push(0, 16'hB003, 1, 1);
    check_eq("B_drop", drop[0], 1);
    check_eq("B_empty", empty[0], 1);
    check_eq("B_dc", dc[0], 0);
    tick();
    check_eq("B_drop_pulse", drop[0], 0);
    push(0, 16'hC000, 0, 0);
    push(0, 16'hC001, 1, 0);
    rd_chk(0, 16'hC000, 0, "C0");
    rd_chk(0, 16'hC001, 1, "C1");

    // 10-word frame into 8 entries overflows and drops
    for (int i = 0; i < 10; i++) begin
      push(0, 16'hD000 + 16'(i), (i == 9), 0);
      if (i == 4) check_eq("D_af_5", af[0], 0);
      if (i == 5) check_eq("D_af_6", af[0], 1);
      if (i == 6) check_eq("D_full_7", full[0], 0);
      if (i == 7) check_eq("D_full_8", full[0], 1);
      if (i == 8) check_eq("D_empty_9", empty[0], 1);
    end
    check_eq("D_drop", drop[0], 1);
    check_eq("D_full_end", full[0], 0);
    check_eq("D_af_end", af[0], 0);
    check_eq("D_dc", dc[0], 0);
    push(0, 16'hE000, 1, 0);
    rd_chk(0, 16'hE000, 1, "E0");

    // Exactly-full 8-word frame commits; write at used==DEPTH with pop is rejected
    for (int i = 0; i < 8; i++) push(0, 16'hF000 + 16'(i), (i == 7), 0);
    check_eq("F_dc", dc[0], 8);
    check_eq("F_full", full[0], 1);
    check_eq("F_pc", pc[0], 1);
    wr_en[0] = 1'b1; din[0] = 16'h9000; wr_last[0] = 1'b1; rd_en[0] = 1'b1;
    tick();
    wr_en[0] = 1'b0; wr_last[0] = 1'b0; rd_en[0] = 1'b0;
    check_eq("G_drop", drop[0], 1);
    check_eq("G_dc", dc[0], 7);
    check_eq("G_pc", pc[0], 1);
    for (int i = 1; i < 8; i++)
      rd_chk(0, 16'hF000 + 16'(i), (i == 7), $sformatf("F%0d", i));
    check_eq("F_empty_end", empty[0], 1);
    check_eq("F_pc_end", pc[0], 0);

    // Frame-count limit
    push(1, 16'h5100, 1, 0);
    push(1, 16'h5101, 1, 0);
    check_eq("H_pc", pc[1], 2);
    check_eq("H_full", full[1], 1);
    push(1, 16'h5102, 1, 0);
    check_eq("H_drop", drop[1], 1);
    check_eq("H_pc2", pc[1], 2);
    check_eq("H_dc", dc[1], 2);
    rd_chk(1, 16'h5100, 1, "H0");
    check_eq("H_pc_pop", pc[1], 1);
    check_eq("H_full_pop", full[1], 0);
    // Commit of a 1-word frame together with popping a last word
    check_eq("H1_dout", dout[1], 16'h5101);
    wr_en[1] = 1'b1; din[1] = 16'h5200; wr_last[1] = 1'b1; rd_en[1] = 1'b1;
    tick();
    wr_en[1] = 1'b0; wr_last[1] = 1'b0; rd_en[1] = 1'b0;
    check_eq("J_pc", pc[1], 1);
    check_eq("J_dc", dc[1], 1);
    rd_chk(1, 16'h5200, 1, "J0");

    // Registered-read wrap across 5 entries
    for (int f = 0; f < 6; f++) begin
      for (int w = 0; w < 3; w++) push(2, 16'h2000 + 16'(f * 16 + w), (w == 2), 0);
      check_eq($sformatf("W%0d_dc", f), dc[2], 3);
      for (int w = 0; w < 3; w++) begin
        pop(2);
        check_eq($sformatf("W%0d_%0d_dout", f, w), dout[2], 16'h2000 + 16'(f * 16 + w));
        check_eq($sformatf("W%0d_%0d_last", f, w), rd_last[2], (w == 2));
      end
      tick();
      check_eq($sformatf("W%0d_hold", f), dout[2], 16'h2000 + 16'(f * 16 + 2));
      check_eq($sformatf("W%0d_empty", f), empty[2], 1);
    end

    // Asynchronous reset mid-frame with two frames committed
    push(0, 16'h7100, 0, 0);
    push(0, 16'h7101, 1, 0);
    push(0, 16'h7102, 1, 0);
    push(0, 16'h7103, 0, 0);
    check_eq("K_pc", pc[0], 2);
    check_eq("K_dc", dc[0], 3);
    rst_n = 1'b0;
    #1;
    check_eq("K_rst_empty", empty[0], 1);
    check_eq("K_rst_dc", dc[0], 0);
    check_eq("K_rst_pc", pc[0], 0);
    check_eq("K_rst_dout", dout[0], 0);
    check_eq("K_rst_last", rd_last[0], 0);
    check_eq("K_rst_full", full[0], 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    push(0, 16'h7300, 0, 0);
    push(0, 16'h7301, 1, 0);
    check_eq("N_dc", dc[0], 2);
    rd_chk(0, 16'h7300, 0, "N0");
    rd_chk(0, 16'h7301, 1, "N1");
    check_eq("N_pc", pc[0], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
